// File: rtl/register_file_if.sv
// Bus bundle for the KGPminiRISC register file: two read address/data pairs and one write port.
// The master drives addresses and write controls; the slave returns the read data.
interface register_file_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic [ADDR_WIDTH-1:0] rs;
    logic [ADDR_WIDTH-1:0] rt;
    logic                  regWrite;
    logic [ADDR_WIDTH-1:0] writeReg;
    logic [DATA_WIDTH-1:0] writeData;
    logic [DATA_WIDTH-1:0] readReg_1;
    logic [DATA_WIDTH-1:0] readReg_2;

    // No handshake: a write is taken on every rising clk edge where regWrite=1;
    // reads are combinational and always valid for the addresses presented.
    modport master (
        output rs, rt, regWrite, writeReg, writeData,
        input  readReg_1, readReg_2
    );

    modport slave (
        input  rs, rt, regWrite, writeReg, writeData,
        output readReg_1, readReg_2
    );
endinterface

// File: rtl/register_file.sv
// Two-read/one-write register file with register 0 hard-wired to zero and async active-high reset.
// Optional write-to-read forwarding is enabled by defining REG_FILE_BYPASS_EN.
module register_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_REGS   = 32
) (
    input  logic           clk,
    input  logic           rst,
    register_file_if.slave rf
);

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
    logic                  write_en;
    logic [DATA_WIDTH-1:0] read_1;
    logic [DATA_WIDTH-1:0] read_2;

    // Writes aimed at register 0 are dropped here, so regs_q[0] never leaves zero.
    assign write_en = rf.regWrite && (rf.writeReg != '0);

    always_comb begin
        regs_d = regs_q;
        if (write_en) begin
            regs_d[rf.writeReg] = rf.writeData;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        read_1 = regs_q[rf.rs];
        read_2 = regs_q[rf.rt];
`ifdef REG_FILE_BYPASS_EN
        if (write_en && (rf.rs == rf.writeReg)) begin
            read_1 = rf.writeData;
        end
        if (write_en && (rf.rt == rf.writeReg)) begin
            read_2 = rf.writeData;
        end
`endif
        // Reset and address 0 override everything, including forwarded data.
        if (rst || (rf.rs == '0)) begin
            read_1 = '0;
        end
        if (rst || (rf.rt == '0)) begin
            read_2 = '0;
        end
    end

    assign rf.readReg_1 = read_1;
    assign rf.readReg_2 = read_2;

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: stimulus pushes expected read data, a monitor compares on each sample strobe.
module tb_register_file;

  localparam int DW = 32;
  localparam int AW = 5;
`ifdef REG_FILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic clk;
  logic rst;
  logic sample;
  int   checks;
  int   errors;

  logic [2*DW-1:0] exp_q[$];
  string           name_q[$];

  register_file_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) rf ();

  register_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(32)) dut (
    .clk (clk),
    .rst (rst),
    .rf  (rf.slave)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish, actual running required done");
    $fatal(1, "timeout");
  end

  // driver tasks
  task automatic drive(input logic [AW-1:0] a_rs, input logic [AW-1:0] a_rt,
                       input logic we, input logic [AW-1:0] wr, input logic [DW-1:0] wd);
    rf.rs        = a_rs;
    rf.rt        = a_rt;
    rf.regWrite  = we;
    rf.writeReg  = wr;
    rf.writeData = wd;
  endtask

  task automatic expect_read(input string name, input logic [DW-1:0] e1, input logic [DW-1:0] e2);
    exp_q.push_back({e1, e2});
    name_q.push_back(name);
    sample = 1'b1;
    #1;
    sample = 1'b0;
  endtask

  // Take the write edge, then stop writing so later edges change nothing.
  task automatic take_edge();
    @(posedge clk);
    #1;
    rf.regWrite = 1'b0;
    #1;
  endtask

  // scoreboard monitor
  initial begin
    logic [2*DW-1:0] e;
    string           n;
    forever begin
      @(posedge sample);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sample_without_expectation: actual empty queue required entry");
      end else begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        checks++;
        if (rf.readReg_1 !== e[2*DW-1:DW]) begin
          errors++;
          $display("FAIL %s readReg_1: actual %h required %h", n, rf.readReg_1, e[2*DW-1:DW]);
        end
        checks++;
        if (rf.readReg_2 !== e[DW-1:0]) begin
          errors++;
          $display("FAIL %s readReg_2: actual %h required %h", n, rf.readReg_2, e[DW-1:0]);
        end
      end
    end
  end

  // stimulus
  initial begin
    checks = 0;
    errors = 0;
    sample = 1'b0;
    rst    = 1'b0;
    drive(5'd21, 5'd5, 1'b0, 5'd0, 32'd0);

    #2 rst = 1'b1;
    #1 expect_read("rst_held", 32'd0, 32'd0);
    #4 rst = 1'b0;
    #1 expect_read("after_reset", 32'd0, 32'd0);

    // write 45 to r21
    @(negedge clk);
    drive(5'd21, 5'd5, 1'b1, 5'd21, 32'd45);
    #2 expect_read("w21_pre_edge", BYPASS ? 32'd45 : 32'd0, 32'd0);
    take_edge();
    expect_read("w21_post_edge", 32'd45, 32'd0);

    // regWrite=0 over two edges leaves r21 alone
    @(negedge clk);
    drive(5'd21, 5'd5, 1'b0, 5'd21, 32'd75);
    @(negedge clk);
    @(negedge clk);
    #2 expect_read("no_write_hold", 32'd45, 32'd0);

    // write 45 to r23, then read r23 and r21
    @(negedge clk);
    drive(5'd23, 5'd5, 1'b1, 5'd23, 32'd45);
    #2 expect_read("w23_pre_edge", BYPASS ? 32'd45 : 32'd0, 32'd0);
    take_edge();
    expect_read("w23_post_edge", 32'd45, 32'd0);
    rf.rs = 5'd21;
    #1 expect_read("r21_unchanged", 32'd45, 32'd0);

    // write to r0 is discarded
    @(negedge clk);
    drive(5'd0, 5'd21, 1'b1, 5'd0, 32'd99);
    #2 expect_read("w0_pre_edge", 32'd0, 32'd45);
    take_edge();
    expect_read("w0_post_edge", 32'd0, 32'd45);

    // rs == rt
    @(negedge clk);
    drive(5'd23, 5'd23, 1'b0, 5'd0, 32'd0);
    #2 expect_read("same_addr", 32'd45, 32'd45);

    // top address, all-ones data
    @(negedge clk);
    drive(5'd31, 5'd23, 1'b1, 5'd31, 32'hFFFF_FFFF);
    take_edge();
    expect_read("w31_ones", 32'hFFFF_FFFF, 32'd45);

    // overwrite r21, read on both ports
    @(negedge clk);
    drive(5'd21, 5'd21, 1'b1, 5'd21, 32'hA5A5_0001);
    take_edge();
    expect_read("overwrite_r21", 32'hA5A5_0001, 32'hA5A5_0001);
    drive(5'd31, 5'd1, 1'b0, 5'd0, 32'd0);
    #1 expect_read("r31_r1", 32'hFFFF_FFFF, 32'd0);

    // async reset between edges, then a write attempted while reset held
    @(negedge clk);
    drive(5'd21, 5'd23, 1'b0, 5'd0, 32'd0);
    #2 rst = 1'b1;
    #1 expect_read("async_reset", 32'd0, 32'd0);
    drive(5'd7, 5'd31, 1'b1, 5'd7, 32'd12);
    @(posedge clk);
    #1 expect_read("write_during_rst", 32'd0, 32'd0);
    rf.regWrite = 1'b0;
    #1 rst = 1'b0;
    #1 expect_read("rst_wins_over_write", 32'd0, 32'd0);
    drive(5'd21, 5'd23, 1'b0, 5'd0, 32'd0);
    #1 expect_read("contents_lost", 32'd0, 32'd0);

    // write r7 after reset; forwarding visible before the edge only when enabled
    @(negedge clk);
    drive(5'd21, 5'd7, 1'b1, 5'd7, 32'd12);
    #2 expect_read("w7_pre_edge", 32'd0, BYPASS ? 32'd12 : 32'd0);
    take_edge();
    expect_read("w7_post_edge", 32'd0, 32'd12);

    #10;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: actual %0d entries required 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
